// File: rtl/fetch_pc_unit_pkg.sv
// Shared fetch-stage definitions: next-PC select codes, FSM state encoding
// and the default reset/handler vectors.
package fetch_pc_unit_pkg;

  localparam logic [31:0] DEFAULT_RESET_VECTOR   = 32'h0000_3000;
  localparam logic [31:0] DEFAULT_HANDLER_VECTOR = 32'h0000_4180;

  typedef enum logic [2:0] {
    PCSRC_SEQ    = 3'b000,
    PCSRC_BRANCH = 3'b001,
    PCSRC_JUMP   = 3'b010,
    PCSRC_JR     = 3'b011,
    PCSRC_ERET   = 3'b100
  } pcsrc_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PENDING = 2'b01,
    ST_SERVICE = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_unit_npc_calc.sv
// Combinational next-PC target arithmetic and select; reports whether the
// chosen target is a redirect (anything other than sequential fetch).
module npc_calc
  import fetch_pc_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] idpc,
  input  logic [31:0] imm32,
  input  logic [25:0] jump_index,
  input  logic [31:0] reg_target,
  input  logic [31:0] epc,
  input  logic [2:0]  pc_src,
  input  logic        branch_taken,
  output logic [31:0] next_pc,
  output logic        redirect
);

  logic [31:0] seq_pc;
  logic [31:0] id_plus4;
  logic [31:0] branch_pc;
  logic [31:0] jump_pc;
  logic [31:0] jr_pc;

  // All arithmetic wraps modulo 2^32 by construction.
  assign seq_pc    = pc + 32'd4;
  assign id_plus4  = idpc + 32'd4;
  assign branch_pc = id_plus4 + (imm32 << 2);
  assign jump_pc   = {id_plus4[31:28], jump_index, 2'b00};
  assign jr_pc     = reg_target & 32'hFFFF_FFFC;

  always_comb begin
    next_pc  = seq_pc;
    redirect = 1'b0;
    case (pc_src)
      PCSRC_BRANCH: begin
        if (branch_taken) begin
          next_pc  = branch_pc;
          redirect = 1'b1;
        end
      end
      PCSRC_JUMP: begin
        next_pc  = jump_pc;
        redirect = 1'b1;
      end
      PCSRC_JR: begin
        next_pc  = jr_pc;
        redirect = 1'b1;
      end
      PCSRC_ERET: begin
        next_pc  = epc;
        redirect = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC register with redirect handling and a three-state interrupt
// entry/return FSM.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR   = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] HANDLER_VECTOR = DEFAULT_HANDLER_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic [2:0]  PCSrc,
  input  logic        BranchTaken,
  input  logic [31:0] IDPC,
  input  logic [31:0] Imm32,
  input  logic [25:0] JumpIndex,
  input  logic [31:0] RegTarget,
  input  logic        IntReq,
  input  logic        IntEn,
  output logic [31:0] PCOut,
  output logic [31:0] PCPlus4Out,
  output logic [31:0] EPCOut,
  output logic        FlushOut,
  output logic        IntAck,
  output logic        InService
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  epc_q, epc_d;
  logic [31:0]  next_pc;
  logic         redirect;
  logic         int_req;
  logic         take_int;
  logic         flush;
  logic         ack;

  npc_calc u_npc_calc (
    .pc           (pc_q),
    .idpc         (IDPC),
    .imm32        (Imm32),
    .jump_index   (JumpIndex),
    .reg_target   (RegTarget),
    .epc          (epc_q),
    .pc_src       (PCSrc),
    .branch_taken (BranchTaken),
    .next_pc      (next_pc),
    .redirect     (redirect)
  );

  assign int_req = IntReq & IntEn;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    epc_d    = epc_q;
    take_int = 1'b0;
    flush    = 1'b0;
    ack      = 1'b0;

    // Entry only on an unstalled sequential cycle so no redirect is lost.
    case (state_q)
      ST_IDLE: begin
        if (int_req) begin
          if (PCWrite && !redirect) take_int = 1'b1;
          else                      state_d  = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (PCWrite) begin
          if (!int_req)       state_d  = ST_IDLE;
          else if (!redirect) take_int = 1'b1;
        end
      end
      ST_SERVICE: begin
        if (PCWrite && (PCSrc == PCSRC_ERET)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (PCWrite) begin
      if (take_int) begin
        epc_d   = pc_q;
        pc_d    = HANDLER_VECTOR;
        state_d = ST_SERVICE;
        ack     = 1'b1;
        flush   = 1'b1;
      end else begin
        pc_d  = next_pc;
        flush = redirect;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_VECTOR;
      epc_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
    end
  end

  assign PCOut      = pc_q;
  assign PCPlus4Out = pc_q + 32'd4;
  assign EPCOut     = epc_q;
  assign FlushOut   = flush;
  assign IntAck     = ack;
  assign InService  = (state_q == ST_SERVICE);

endmodule
